exe_stage: RTL

//  ARM execute stage: consumes the ID/EXE pipeline register outputs, builds Val2 (shifter operand),

---
 rtl/exe_stage_pkg.sv | 38 +++
 rtl/exe_stage_val2_generator.sv | 48 ++++
 rtl/exe_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU command codes, shift types,
// forwarding selects and NZCV bit positions.
// Pure declarations, no logic.
package exe_stage_pkg;

    typedef enum logic [3:0] {
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } exe_cmd_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_ALU     = 2'b01,
        FWD_WB      = 2'b10,
        FWD_REG_ALT = 2'b11
    } fwd_sel_e;

    // Bit positions inside SR = {N,Z,C,V}
    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

endpackage

// File: rtl/exe_stage_val2_generator.sv
// Purpose: builds the ALU second operand (Val2) from offset, rotated immediate or shifted Rm.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; output tracks inputs continuously.
module exe_stage_val2_generator
    import exe_stage_pkg::*;
(
    input  logic        mem_en,
    input  logic        imm,
    input  logic [11:0] shift_operand,
    input  logic [31:0] val_rm,
    output logic [31:0] val2
);

    logic [4:0]  rot_amt;
    logic [4:0]  sh_amt;
    logic [31:0] imm_base;
    logic [63:0] imm_dbl;
    logic [63:0] rm_dbl;
    logic        unused_bit4;

    // Register-specified shifts are not supported, so bit 4 carries no meaning here
    assign unused_bit4 = shift_operand[4];

    assign rot_amt  = {shift_operand[11:8], 1'b0};
    assign sh_amt   = shift_operand[11:7];
    assign imm_base = {24'd0, shift_operand[7:0]};
    assign imm_dbl  = {imm_base, imm_base} >> rot_amt;
    assign rm_dbl   = {val_rm, val_rm} >> sh_amt;

    // Priority: memory offset, then rotated immediate, then immediate-shifted Rm
    always_comb begin
        val2 = val_rm;
        if (mem_en) begin
            val2 = {{20{shift_operand[11]}}, shift_operand};
        end else if (imm) begin
            val2 = imm_dbl[31:0];
        end else begin
            case (shift_operand[6:5])
                SH_LSL:  val2 = val_rm << sh_amt;
                SH_LSR:  val2 = val_rm >> sh_amt;
                SH_ASR:  val2 = $signed(val_rm) >>> sh_amt;
                SH_ROR:  val2 = rm_dbl[31:0];
                default: val2 = val_rm;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Purpose: ARM execute stage - forwarding, Val2, ALU, NZCV register, EXE/MEM register.
// Latency: 1 cycle to *_mem outputs and SR; Branch_taken/Branch_addr are combinational.
// Backpressure: freeze holds SR and every registered output; combinational outputs keep tracking.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        WB_EN,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic        Branch,
    input  logic        S,
    input  logic [3:0]  EXE_CMD,
    input  logic [31:0] PC,
    input  logic [31:0] Val_Rn,
    input  logic [31:0] Val_Rm,
    input  logic        imm,
    input  logic [11:0] Shift_operand,
    input  logic [23:0] Signed_imm_24,
    input  logic [3:0]  Dest,
    input  logic [1:0]  sel_src1,
    input  logic [1:0]  sel_src2,
    input  logic [31:0] alu_res_fwd,
    input  logic [31:0] wb_value_fwd,
    output logic        Branch_taken,
    output logic [31:0] Branch_addr,
    output logic [3:0]  SR,
    output logic        WB_EN_mem,
    output logic        MEM_R_EN_mem,
    output logic        MEM_W_EN_mem,
    output logic [31:0] ALU_res_mem,
    output logic [31:0] Val_Rm_mem,
    output logic [3:0]  Dest_mem
);

    logic [31:0] rn_fwd, rm_fwd, val2, op2, alu_res;
    logic [32:0] sum;
    logic        cin, carry, ovf;
    logic [3:0]  alu_flags;

    logic [3:0]  sr_q, sr_d;
    logic        wb_en_q, wb_en_d, mem_r_q, mem_r_d, mem_w_q, mem_w_d;
    logic [31:0] alu_res_q, alu_res_d, val_rm_q, val_rm_d;
    logic [3:0]  dest_q, dest_d;

    // Operand forwarding; 11 falls back to the register-file value like 00
    always_comb begin
        case (sel_src1)
            FWD_ALU: rn_fwd = alu_res_fwd;
            FWD_WB:  rn_fwd = wb_value_fwd;
            default: rn_fwd = Val_Rn;
        endcase
        case (sel_src2)
            FWD_ALU: rm_fwd = alu_res_fwd;
            FWD_WB:  rm_fwd = wb_value_fwd;
            default: rm_fwd = Val_Rm;
        endcase
    end

    exe_stage_val2_generator u_val2 (
        .mem_en        (MEM_R_EN | MEM_W_EN),
        .imm           (imm),
        .shift_operand (Shift_operand),
        .val_rm        (rm_fwd),
        .val2          (val2)
    );

    // Subtraction is done as Rn + ~Val2 + cin so the carry out is directly NOT borrow
    always_comb begin
        op2 = val2;
        cin = 1'b0;
        case (EXE_CMD)
            CMD_ADC: cin = sr_q[SR_C];
            CMD_SUB: begin op2 = ~val2; cin = 1'b1;       end
            CMD_SBC: begin op2 = ~val2; cin = sr_q[SR_C]; end
            default: ;
        endcase
    end

    assign sum = {1'b0, rn_fwd} + {1'b0, op2} + {32'd0, cin};

    // ALU result mux; logic/move and unknown ops keep the stored C and V
    always_comb begin
        alu_res = 32'd0;
        carry   = sr_q[SR_C];
        ovf     = sr_q[SR_V];
        case (EXE_CMD)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
                alu_res = sum[31:0];
                carry   = sum[32];
                ovf     = (rn_fwd[31] == op2[31]) && (sum[31] != rn_fwd[31]);
            end
            CMD_AND: alu_res = rn_fwd & val2;
            CMD_ORR: alu_res = rn_fwd | val2;
            CMD_EOR: alu_res = rn_fwd ^ val2;
            default: alu_res = 32'd0;
        endcase
        alu_flags = {alu_res[31], (alu_res == 32'd0), carry, ovf};
    end

    // Next-state for SR and EXE/MEM register: hold on freeze, SR loads only when S is set
    always_comb begin
        sr_d      = sr_q;
        wb_en_d   = wb_en_q;
        mem_r_d   = mem_r_q;
        mem_w_d   = mem_w_q;
        alu_res_d = alu_res_q;
        val_rm_d  = val_rm_q;
        dest_d    = dest_q;
        if (!freeze) begin
            wb_en_d   = WB_EN;
            mem_r_d   = MEM_R_EN;
            mem_w_d   = MEM_W_EN;
            alu_res_d = alu_res;
            val_rm_d  = rm_fwd;
            dest_d    = Dest;
            if (S) begin
                sr_d = alu_flags;
            end
        end
    end

    // State registers; reset takes priority over freeze
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q      <= 4'd0;
            wb_en_q   <= 1'b0;
            mem_r_q   <= 1'b0;
            mem_w_q   <= 1'b0;
            alu_res_q <= 32'd0;
            val_rm_q  <= 32'd0;
            dest_q    <= 4'd0;
        end else begin
            sr_q      <= sr_d;
            wb_en_q   <= wb_en_d;
            mem_r_q   <= mem_r_d;
            mem_w_q   <= mem_w_d;
            alu_res_q <= alu_res_d;
            val_rm_q  <= val_rm_d;
            dest_q    <= dest_d;
        end
    end

    assign Branch_taken = Branch;
    assign Branch_addr  = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

    assign SR           = sr_q;
    assign WB_EN_mem    = wb_en_q;
    assign MEM_R_EN_mem = mem_r_q;
    assign MEM_W_EN_mem = mem_w_q;
    assign ALU_res_mem  = alu_res_q;
    assign Val_Rm_mem   = val_rm_q;
    assign Dest_mem     = dest_q;

endmodule
